// File: rtl/data_register_arbiter.sv
// Arbiter and access sequencer for the shared data register block.
// Two requesters share one register block through a req/ack handshake with
// round-robin tie-breaking. Each grant performs exactly one access:
// IDLE (grant) -> ACCESS (bus driven, write on exit) -> DONE (ack, result).
// Requester 0 may not write the previous hash; such a write is turned into a
// read of the unchanged hash and flagged with err0.
module data_register_arbiter #(
    parameter int DATA_W = 48,
    parameter int HASH_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              type0,
    input  logic              type1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              busy,
    output logic              reg_access_type,
    output logic              reg_wren,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_result
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_reg, last_next;
    logic              type_reg, type_next;
    logic              we_reg, we_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic [1:0]             req_vec;
    logic [1:0]             type_vec;
    logic [1:0]             we_vec;
    logic [1:0][DATA_W-1:0] wdata_vec;
    logic [1:0][DATA_W-1:0] rdata_vec;
    logic [1:0]             ack_vec;
    logic                   sel;
    logic                   rejected;
    logic                   in_done;
    logic [DATA_W-1:0]      hash_data;

    assign req_vec   = {req1, req0};
    assign type_vec  = {type1, type0};
    assign we_vec    = {we1, we0};
    assign wdata_vec = {wdata1, wdata0};

    // A hash write from requester 0 is performed as a harmless read.
    assign rejected = (grant_reg == 1'b0) && type_reg && we_reg;

    // A reset asserted during DONE cancels the completion pulse.
    assign in_done = (state_reg == DONE) && resetn;

    // The block keeps only the low hash bits; the rest of the bus is zeroed.
    assign hash_data = {{(DATA_W-HASH_W){1'b0}}, wdata_reg[HASH_W-1:0]};

    // State, latched request fields and round-robin pointer
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            last_reg  <= 1'b1;
            type_reg  <= 1'b0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            type_reg  <= type_next;
            we_reg    <= we_next;
            wdata_reg <= wdata_next;
        end
    end

    // Arbitration in IDLE and fixed three-state access sequence
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        type_next  = type_reg;
        we_next    = we_reg;
        wdata_next = wdata_reg;
        // On a tie the requester that did not win last time is chosen.
        sel        = (&req_vec) ? ~last_reg : req_vec[1];
        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    grant_next = sel;
                    last_next  = sel;
                    type_next  = type_vec[sel];
                    we_next    = we_vec[sel];
                    wdata_next = wdata_vec[sel];
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register block bus: live only in ACCESS, target held through DONE
    always_comb begin
        reg_access_type = 1'b0;
        reg_wren        = 1'b0;
        reg_data_in     = '0;
        case (state_reg)
            ACCESS: begin
                reg_access_type = type_reg;
                reg_wren        = we_reg && !rejected;
                reg_data_in     = type_reg ? hash_data : wdata_reg;
            end
            DONE: begin
                reg_access_type = type_reg;
            end
            default: begin
                reg_access_type = 1'b0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [DATA_W-1:0] rdata_reg;

            assign ack_vec[gi] = in_done && (grant_reg == 1'(gi));

            // Hold the result until this requester's next completion
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    rdata_reg <= '0;
                end else if (ack_vec[gi]) begin
                    rdata_reg <= reg_result;
                end
            end

            // Forward the live result during the ack cycle so it is valid with ack.
            assign rdata_vec[gi] = ack_vec[gi] ? reg_result : rdata_reg;
        end
    endgenerate

    assign ack0   = ack_vec[0];
    assign ack1   = ack_vec[1];
    assign rdata0 = rdata_vec[0];
    assign rdata1 = rdata_vec[1];
    assign err0   = ack_vec[0] && rejected;
    assign busy   = (state_reg != IDLE);

endmodule
